// File: rtl/riscv_dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_pkg
// Purpose  : Shared types and helpers for the RV64I data-memory responder:
//            the access-size encoding, the responder FSM states, the size to
//            byte-mask conversion and the alignment check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    // Access size, taken straight from funct3[1:0] of the load/store.
    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10,
        MEM_D = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

    // Byte lanes covered by an access of the given size, starting at lane 0.
    function automatic logic [7:0] size_bmask(input mem_size_e size);
        case (size)
            MEM_B:   return 8'h01;
            MEM_H:   return 8'h03;
            MEM_W:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // An access is misaligned when the byte offset is not a multiple of the
    // access size (1, 2, 4 or 8 bytes).
    function automatic logic is_misaligned(input mem_size_e size, input logic [2:0] off);
        logic [2:0] low;
        case (size)
            MEM_B:   low = 3'd0;
            MEM_H:   low = 3'd1;
            MEM_W:   low = 3'd3;
            default: low = 3'd7;
        endcase
        return (off & low) != 3'd0;
    endfunction

endpackage : riscv_mem_pkg
`default_nettype wire

// File: rtl/riscv_dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_dmem_responder_if
// Purpose  : Load/store request/response channel between the memory-access
//            stage (master) and the data-memory responder (slave).
// Ports    : req_valid/req_ready/req_we/req_size/req_addr/req_wdata
//            resp_valid/resp_ready/resp_rdata/resp_err
// Revision : 1.0 - initial release
// ============================================================================
interface riscv_dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface : riscv_dmem_responder_if
`default_nettype wire

// File: rtl/riscv_dmem_responder_bank.sv
`default_nettype none
// ============================================================================
// Module   : riscv_dmem_bank
// Purpose  : DEPTH x 64-bit doubleword array with byte-enabled synchronous
//            write and synchronous (registered) read. Contents are never
//            reset.
// Ports    : clk      - clock
//            i_we     - write strobe          i_be   - byte enables
//            i_re     - read strobe           i_addr - doubleword index
//            i_wdata  - lane-aligned write data
//            o_rdata  - doubleword captured by the last read strobe
// Revision : 1.0 - initial release
// ============================================================================
module riscv_dmem_bank #(
    parameter int DEPTH = 1024
) (
    input  wire logic                     clk,
    input  wire logic                     i_we,
    input  wire logic [7:0]               i_be,
    input  wire logic                     i_re,
    input  wire logic [$clog2(DEPTH)-1:0] i_addr,
    input  wire logic [63:0]              i_wdata,
    output      logic [63:0]              o_rdata
);

    logic [63:0] r_mem [DEPTH];
    logic [63:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 8; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        // Read register only updates on a load, so it holds the loaded
        // doubleword for as long as the response is pending.
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : riscv_dmem_bank
`default_nettype wire

// File: rtl/riscv_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : riscv_dmem_responder
// Purpose  : Single-outstanding data-memory responder for the RV64I pipeline.
//            Performs byte-enabled stores and aligned loads against an
//            internal array and returns right-justified, zero-filled load
//            data (or an error) LATENCY cycles after acceptance.
// Ports    : clk  - clock (rising edge)
//            rst  - synchronous active-high reset
//            bus  - riscv_dmem_responder_if slave modport
// Revision : 1.0 - initial release
// ============================================================================
module riscv_dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input wire logic              clk,
    input wire logic              rst,
    riscv_dmem_responder_if.slave bus
);

    localparam int          c_AW       = $clog2(DEPTH);
    localparam logic [3:0]  c_CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    dmem_state_e r_state;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic        r_load_ok;      // response carries load data (load, no error)
    logic [2:0]  r_off;
    mem_size_e   r_size;
    logic [3:0]  r_cnt;

    // Request decode
    mem_size_e   w_size;
    logic [2:0]  w_off;
    logic        w_accept;
    logic        w_err;
    logic [7:0]  w_be;
    logic [63:0] w_wdata;
    logic [63:0] w_bank_rdata;
    logic [63:0] w_rd_shift;
    logic [63:0] w_rd_mask;
    logic [7:0]  w_rd_bmask;

    assign w_size   = mem_size_e'(bus.req_size);
    assign w_off    = bus.req_addr[2:0];
    assign w_accept = bus.req_valid & r_req_ready;
    assign w_err    = is_misaligned(w_size, w_off) | (bus.req_addr[63:3] >= 61'(DEPTH));
    assign w_be     = size_bmask(w_size) << w_off;
    assign w_wdata  = bus.req_wdata << {w_off, 3'b000};

    riscv_dmem_bank #(
        .DEPTH (DEPTH)
    ) u_bank (
        .clk     (clk),
        .i_we    (w_accept & ~w_err & bus.req_we),
        .i_be    (w_be),
        .i_re    (w_accept & ~w_err & ~bus.req_we),
        .i_addr  (bus.req_addr[c_AW+2:3]),
        .i_wdata (w_wdata),
        .o_rdata (w_bank_rdata)
    );

    // The bank read register and the captured offset/size are all frozen
    // until the next accept, so the extracted load data stays stable for the
    // whole response phase.
    assign w_rd_shift = w_bank_rdata >> {r_off, 3'b000};
    assign w_rd_bmask = size_bmask(r_size);

    always_comb begin
        w_rd_mask = '0;
        for (int i = 0; i < 8; i++) begin
            w_rd_mask[8*i +: 8] = {8{w_rd_bmask[i]}};
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_load_ok ? (w_rd_shift & w_rd_mask) : 64'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_load_ok    <= 1'b0;
            r_off        <= 3'd0;
            r_size       <= MEM_B;
            r_cnt        <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_resp_err  <= w_err;
                        r_load_ok   <= ~w_err & ~bus.req_we;
                        r_off       <= w_off;
                        r_size      <= w_size;
                        if (LATENCY <= 1) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= c_CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : riscv_dmem_responder
`default_nettype wire

// File: doc/riscv_dmem_responder.md
# riscv_dmem_responder

Data-memory responder for the RV64I pipeline: the slave end of the load/store request interface driven by the memory-access stage. It accepts one request at a time, performs byte-enabled stores or aligned loads against an internal doubleword array, and returns right-justified read data or an error after a programmable wait-state latency. It serves as the functional D-cache stand-in until the real cache is integrated, and it defines the handshake that cache must later honour.

## Interface
- DEPTH, 1024, number of 64-bit doublewords in the array; power of two.
- LATENCY, 1, cycles from request acceptance to `resp_valid`; legal range 1..15.
- clk  in  1  the single clock. All logic is rising-edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size, from funct3[1:0]: 00 B, 01 H, 10 W, 11 D.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  64  load data, right-justified and zero-filled above the access size. 0 for stores and errors.
- resp_err  out  1  access was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- `req_ready` is 1 only in IDLE. A request is accepted when `req_valid & req_ready` is true at a clock edge.
- On accept, the error check runs:
  - Misaligned: `req_addr[2:0]` is not a multiple of 2^size.
  - Out of range: `req_addr[63:3] >= DEPTH`.
- On accept with no error:
  - Store: write at the accept edge. Byte enables = (size mask 0x01/0x03/0x0F/0xFF) << `addr[2:0]`. Data = `req_wdata` << (8*`addr[2:0]`).
  - Load: the doubleword is read at the accept edge. The result is shifted right by 8*`addr[2:0]`, masked to the access size, and captured into the response register.
- On accept with an error: no array write; the response is `rdata=0`, `err=1`.
- State transitions after accept:
  - LATENCY=1: go to RESP.
  - Otherwise: go to WAIT with `cnt=LATENCY-2`.
  - WAIT decrements `cnt` and moves to RESP when `cnt==0`.
- RESP: `resp_valid=1`. The response fields are held stable until `resp_valid & resp_ready`, then the FSM returns to IDLE.
- Stores always produce a response (`rdata=0`), so the requester sees in-order completion.
- Sign extension is the requester's job; this block never sign-extends.

## Timing
- Accept at edge T → `resp_valid` rises in the cycle following edge T+LATENCY-1, i.e. exactly LATENCY cycles after accept.
- Throughput is one request per LATENCY+1 cycles when `resp_ready` is held high. Back-to-back accept is impossible because `req_ready` is 0 during the RESP handshake cycle.
- Store-then-load to the same address: the load always observes the store, because only one request is outstanding and the write commits at its own accept edge.
- Reset behaviour:
  - Output values after the reset edge: state=IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `cnt=0`.
  - Array contents are not reset.
- Reset mid-WAIT or mid-RESP: the pending response is discarded, and a store that was already accepted remains committed.
- `resp_ready` high while not in RESP: ignored.
- `req_valid` while `req_ready=0`: ignored. The requester must hold the request until accepted.

## Structure
- Package `riscv_mem_pkg`:
  - `mem_size_e` (MEM_B=2'b00, MEM_H, MEM_W, MEM_D).
  - `dmem_state_e` (IDLE, WAIT, RESP).
  - Function returning the size byte-mask.
  - Function computing the misalignment check.
- Sub-module `riscv_dmem_bank`: DEPTH×64 array with synchronous write using an 8-bit byte enable, and synchronous read. Only the array lives here; the FSM, shifting and error logic stay in the top.
- Target size: 150–250 RTL lines total.

## Test plan
- Store then byte load (LATENCY=1): SD addr 0x10 data 0x1122334455667788, then load B at 0x13 → `resp_rdata=0x55`, `err=0`, `resp_valid` exactly 1 cycle after each accept.
- Partial store merge: after the SD above, SH 0xBEEF at 0x16, then LD 0x10 → `0xBEEF334455667788`.
- Misaligned and out-of-range errors:
  - Load W at 0x12 → `err=1`, `rdata=0`.
  - SD at 0x2000 (DEPTH=1024) → `err=1`, and a following LD 0x0 shows the array unchanged.
- Backpressure (LATENCY=3): accept an LD; `resp_valid` rises 3 cycles later. Hold `resp_ready=0` for 5 cycles → `rdata`/`err` stable, `req_ready=0` throughout. Raise `resp_ready` → IDLE next cycle, `req_ready=1`.
- Reset mid-operation (LATENCY=4): accept SD 0xAA at 0x8 and assert `rst` in the second WAIT cycle → next cycle `resp_valid=0`, `req_ready=1`. A following LD 0x8 returns 0xAA.
